// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, PC step and sizing helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_INC = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instruction} pairs with flush; flush wins over push/pop.
// Pop on empty and push during flush are ignored; the caller guarantees no push when full.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_push_pc,
    input  logic [DATA_W-1:0]             i_push_inst,
    input  logic                          i_pop,
    input  logic                          i_flush,
    output logic [DATA_W-1:0]             o_head_pc,
    output logic [DATA_W-1:0]             o_head_inst,
    output logic [cnt_width(DEPTH)-1:0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_inst_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_push_ok = i_push && !i_flush;
    assign w_pop_ok  = i_pop && !i_flush && !o_empty;

    assign o_head_pc   = r_pc_mem[r_rd_ptr];
    assign o_head_inst = r_inst_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_pc_mem[r_wr_ptr]   <= i_push_pc;
            r_inst_mem[r_wr_ptr] <= i_push_inst;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one outstanding imem read at a time, queues {pc, inst} for decode,
// and drives the PC register load port with pc+4 or a redirect target (registered, one-cycle pulse).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_next,
    output logic              pc_ld,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [DATA_W-1:0] inst_pc
);
    localparam int CNT_W = cnt_width(DEPTH);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_imem_req;
    logic              w_imem_req_nxt;
    logic [DATA_W-1:0] r_imem_addr;
    logic [DATA_W-1:0] w_imem_addr_nxt;
    logic              r_pc_ld;
    logic              w_pc_ld_nxt;
    logic [DATA_W-1:0] r_pc_next;
    logic [DATA_W-1:0] w_pc_next_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_can_issue;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    assign w_can_issue = (w_count < CNT_W'(DEPTH));
    assign inst_valid  = (w_count != '0) && !redirect_valid;
    assign w_pop       = inst_valid && inst_ready;

    assign imem_req  = r_imem_req;
    assign imem_addr = r_imem_addr;
    assign pc_ld     = r_pc_ld;
    assign pc_next   = r_pc_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_pc_ld     <= 1'b0;
            r_pc_next   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_imem_req  <= w_imem_req_nxt;
            r_imem_addr <= w_imem_addr_nxt;
            r_pc_ld     <= w_pc_ld_nxt;
            r_pc_next   <= w_pc_next_nxt;
        end
    end

    // A redirect always lands in SETTLE unless a read is still in flight to be drained.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (redirect_valid)   w_state_nxt = ST_SETTLE;
                else if (w_can_issue) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) w_state_nxt = imem_ack ? ST_SETTLE : ST_DISCARD;
                else if (imem_ack)  w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_state_nxt = redirect_valid ? ST_SETTLE : ST_IDLE;
            end
            ST_DISCARD: begin
                if (imem_ack) w_state_nxt = redirect_valid ? ST_SETTLE : ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_imem_req_nxt  = r_imem_req;
        w_imem_addr_nxt = r_imem_addr;
        w_pc_ld_nxt     = 1'b0;
        w_pc_next_nxt   = r_pc_next;
        w_push          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!redirect_valid && w_can_issue) begin
                    w_imem_req_nxt  = 1'b1;
                    w_imem_addr_nxt = pc_in;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    w_imem_req_nxt = 1'b0;
                    if (!redirect_valid) begin
                        w_push        = 1'b1;
                        w_pc_ld_nxt   = 1'b1;
                        w_pc_next_nxt = r_imem_addr + DATA_W'(PC_INC);
                    end
                end
            end
            ST_SETTLE: begin
            end
            ST_DISCARD: begin
                if (imem_ack) w_imem_req_nxt = 1'b0;
            end
        endcase
        if (redirect_valid) begin
            w_pc_ld_nxt   = 1'b1;
            w_pc_next_nxt = redirect_pc;
        end
    end

    fetch_queue #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_pc   (r_imem_addr),
        .i_push_inst (imem_rdata),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head_pc   (inst_pc),
        .o_head_inst (inst_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) w_push |-> !w_full);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) w_pop |-> !w_empty);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against an instruction-stream model.
module tb_fetch_unit;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] pc_next;
    logic              pc_ld;
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [DATA_W-1:0] inst_pc;

    int          checks;
    int          errors;
    logic [31:0] pc_reg;
    logic [31:0] pc_rst_val;
    logic [31:0] seed;
    int          mem_lat;
    bit          mem_ovr;
    logic [31:0] mem_ovr_dat;

    fetch_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_next        (pc_next),
        .pc_ld          (pc_ld),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The PC register that fetch_unit loads; its reset value is chosen per test.
    always @(posedge clk or negedge rst) begin
        if (!rst)       pc_reg <= pc_rst_val;
        else if (pc_ld) pc_reg <= pc_next;
    end
    assign pc_in = pc_reg;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // Instruction memory: acks after mem_lat cycles of an asserted request.
    initial begin
        int wait_cnt;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req && !imem_ack) begin
                if (wait_cnt >= mem_lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_ovr ? mem_ovr_dat : word_at(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] v);
        pc_rst_val     = v;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        mem_ovr        = 1'b0;
        mem_lat        = 0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pc_rst_val = 32'h0;
        repeat (3) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b required 0", imem_req); end
        checks++; if (pc_ld !== 1'b0) begin errors++; $display("FAIL reset_pc_ld got %b required 0", pc_ld); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b required 0", inst_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h required 0", imem_addr); end
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc_next got %h required 0", pc_next); end
        rst = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_release_req got %b required 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_release_addr got %h required 0", imem_addr); end
    endtask

    task automatic test_straight();
        int n;
        do_reset(32'h0);
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!imem_req && n < 20) begin tick(); n++; end
            checks++; if (n !== 1) begin errors++; $display("FAIL straight_issue_gap[%0d] got %0d cycles required 1", k, n); end
            checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL straight_addr[%0d] got %h required %h", k, imem_addr, 4 * k); end
            n = 0;
            while (!pc_ld && n < 20) begin tick(); n++; end
            checks++; if (pc_next !== 32'(4 * k + 4) || pc_ld !== 1'b1) begin errors++; $display("FAIL straight_pc_next[%0d] got ld=%b %h required ld=1 %h", k, pc_ld, pc_next, 4 * k + 4); end
            checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_data !== word_at(32'(4 * k))) begin
                errors++; $display("FAIL straight_inst[%0d] got v=%b pc=%h d=%h required v=1 pc=%h d=%h", k, inst_valid, inst_pc, inst_data, 4 * k, word_at(32'(4 * k)));
            end
            tick();
            checks++; if (pc_ld !== 1'b0) begin errors++; $display("FAIL straight_ld_pulse[%0d] got %b required 0", k, pc_ld); end
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] addrs[$];
        logic        prev;
        int          n;
        do_reset(32'h0);
        prev = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (imem_req && !prev) addrs.push_back(imem_addr);
            prev = imem_req;
        end
        checks++; if (addrs.size() !== DEPTH) begin errors++; $display("FAIL bp_fetch_count got %0d required %0d", addrs.size(), DEPTH); end
        for (int i = 0; i < addrs.size() && i < DEPTH; i++) begin
            checks++; if (addrs[i] !== 32'(4 * i)) begin errors++; $display("FAIL bp_addr[%0d] got %h required %h", i, addrs[i], 4 * i); end
        end
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL bp_full_hold got req=%b v=%b pc=%h required req=0 v=1 pc=0", imem_req, inst_valid, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL bp_refetch got req=%b addr=%h required req=1 addr=10", imem_req, imem_addr); end
        prev = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (imem_req && !prev) n++;
            prev = imem_req;
        end
        checks++; if (n !== 0 || inst_pc !== 32'h4) begin errors++; $display("FAIL bp_after_pop got extra_reqs=%0d head=%h required 0 and 4", n, inst_pc); end
    endtask

    task automatic test_redirect_idle();
        int n;
        int lds;
        do_reset(32'h0);
        lds = 0;
        n = 0;
        while (lds < 2 && n < 30) begin tick(); n++; if (pc_ld) lds++; end
        tick();
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin errors++; $display("FAIL rdi_pre got req=%b v=%b required req=0 v=1", imem_req, inst_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdi_mask got %b required 0", inst_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++; if (pc_ld !== 1'b1 || pc_next !== 32'h100) begin errors++; $display("FAIL rdi_ld got ld=%b %h required ld=1 100", pc_ld, pc_next); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rdi_flush got v=%b required 0", inst_valid); end
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdi_next_addr got req=%b %h required req=1 100", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_req();
        int n;
        int extra_ld;
        int vld_seen;
        int acks;
        do_reset(32'h20);
        mem_lat     = 3;
        mem_ovr     = 1'b1;
        mem_ovr_dat = 32'hDEAD_BEEF;
        inst_ready  = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || imem_ack !== 1'b0) begin
            errors++; $display("FAIL rdr_pending got req=%b addr=%h ack=%b required 1 20 0", imem_req, imem_addr, imem_ack);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        checks++; if (pc_ld !== 1'b1 || pc_next !== 32'h200 || imem_req !== 1'b1) begin
            errors++; $display("FAIL rdr_ld got ld=%b %h req=%b required ld=1 200 req=1", pc_ld, pc_next, imem_req);
        end
        extra_ld = 0; vld_seen = 0; acks = 0; n = 0;
        while (imem_req && n < 20) begin
            tick(); n++;
            if (pc_ld) extra_ld++;
            if (inst_valid) vld_seen++;
            if (imem_ack) acks++;
        end
        checks++; if (extra_ld !== 0 || vld_seen !== 0 || acks !== 1 || imem_req !== 1'b0) begin
            errors++; $display("FAIL rdr_discard got extra_ld=%0d vld=%0d acks=%0d req=%b required 0 0 1 0", extra_ld, vld_seen, acks, imem_req);
        end
        mem_ovr = 1'b0;
        mem_lat = 0;
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rdr_next_addr got req=%b %h required req=1 200", imem_req, imem_addr); end
        n = 0;
        while (!pc_ld && n < 20) begin tick(); n++; end
        checks++; if (pc_next !== 32'h204 || inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== word_at(32'h200)) begin
            errors++; $display("FAIL rdr_deliver got next=%h v=%b pc=%h d=%h required 204 1 200 %h", pc_next, inst_valid, inst_pc, inst_data, word_at(32'h200));
        end
        inst_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        int lds;
        do_reset(32'h0);
        lds = 0; n = 0;
        while (lds < 2 && n < 30) begin tick(); n++; if (pc_ld) lds++; end
        mem_lat = 6;
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1 || inst_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got req=%b v=%b required 1 1", imem_req, inst_valid); end
        #2;
        pc_rst_val = 32'h40;
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc_ld !== 1'b0) begin
            errors++; $display("FAIL arst_async got req=%b v=%b ld=%b required 0 0 0", imem_req, inst_valid, pc_ld);
        end
        repeat (2) tick();
        rst = 1'b1;
        mem_lat = 0;
        n = 0;
        while (!imem_req && n < 20) begin tick(); n++; end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
            errors++; $display("FAIL arst_restart got req=%b addr=%h v=%b required 1 40 0", imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        logic [31:0] exp_addr;
        logic        prev;
        do_reset(32'hFFFF_FFF8);
        inst_ready = 1'b1;
        prev = 1'b0;
        for (int c = 0; c < 20 && addrs.size() < 3; c++) begin
            tick();
            if (imem_req && !prev) addrs.push_back(imem_addr);
            prev = imem_req;
        end
        checks++; if (addrs.size() !== 3) begin errors++; $display("FAIL wrap_count got %0d required 3", addrs.size()); end
        exp_addr = 32'hFFFF_FFF8;
        for (int i = 0; i < addrs.size(); i++) begin
            checks++; if (addrs[i] !== exp_addr) begin errors++; $display("FAIL wrap_addr[%0d] got %h required %h", i, addrs[i], exp_addr); end
            exp_addr = exp_addr + 32'd4;
        end
        inst_ready = 1'b0;
    endtask

    // Instruction-stream model: fetch address advances by 4 per delivered word, jumps on redirect,
    // and decode sees delivered words in order, with a redirect discarding everything undelivered.
    task automatic test_random();
        logic [31:0] mq[$];
        logic [31:0] exp_fetch, exp_next, cur_req, tgt, head, start;
        logic        exp_ld, prev_req, stale, exp_vld;
        start = $urandom & 32'hFFFF_FFFC;
        do_reset(start);
        exp_fetch = start; cur_req = start; exp_next = '0;
        exp_ld = 1'b0; prev_req = 1'b0; stale = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            inst_ready     = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            tgt            = $urandom & 32'hFFFF_FFFC;
            redirect_pc    = tgt;
            #1;
            checks++; if (pc_ld !== exp_ld) begin errors++; $display("FAIL rnd_pc_ld cyc %0d got %b required %b", cyc, pc_ld, exp_ld); end
            if (exp_ld) begin
                checks++; if (pc_next !== exp_next) begin errors++; $display("FAIL rnd_pc_next cyc %0d got %h required %h", cyc, pc_next, exp_next); end
            end
            if (imem_req && !prev_req) begin
                cur_req = exp_fetch;
                checks++; if (imem_addr !== cur_req) begin errors++; $display("FAIL rnd_fetch_addr cyc %0d got %h required %h", cyc, imem_addr, cur_req); end
                mem_lat = $urandom_range(0, 3);
            end
            exp_vld = (mq.size() != 0) && !redirect_valid;
            checks++; if (inst_valid !== exp_vld) begin errors++; $display("FAIL rnd_inst_valid cyc %0d got %b required %b", cyc, inst_valid, exp_vld); end
            if (exp_vld && inst_ready) begin
                head = mq.pop_front();
                checks++; if (inst_pc !== head || inst_data !== word_at(head)) begin
                    errors++; $display("FAIL rnd_inst cyc %0d got pc=%h d=%h required pc=%h d=%h", cyc, inst_pc, inst_data, head, word_at(head));
                end
            end
            exp_ld = 1'b0;
            if (redirect_valid) begin
                mq.delete();
                exp_fetch = tgt;
                exp_next  = tgt;
                exp_ld    = 1'b1;
                stale     = imem_req && !imem_ack;
            end else if (imem_req && imem_ack) begin
                if (!stale) begin
                    mq.push_back(cur_req);
                    exp_fetch = cur_req + 32'd4;
                    exp_next  = exp_fetch;
                    exp_ld    = 1'b1;
                    checks++; if (mq.size() > DEPTH) begin errors++; $display("FAIL rnd_overflow cyc %0d got %0d entries required <= %0d", cyc, mq.size(), DEPTH); end
                end
                stale = 1'b0;
            end
            prev_req = imem_req;
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b0;
        pc_rst_val     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        mem_lat        = 0;
        mem_ovr        = 1'b0;
        mem_ovr_dat    = '0;
        seed           = $urandom;
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect_idle();
        test_redirect_req();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch sequencer; the read side of the program counter register.
- Reads the current PC (pc_in) and issues one instruction-memory read at a time.
- Queues fetched {pc, instruction} pairs for decode.
- Drives the PC register's data_in/ld pair: the sequential next PC (pc+4), or a branch/jump redirect target.

Parameters:
- DATA_W, 32, instruction and address width.
- DEPTH, 4, instruction queue entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- pc_in  input  DATA_W  current value of the program counter register.
- pc_next  output  DATA_W  to PC data_in.
- pc_ld  output  1  to PC ld; one-cycle pulse.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  DATA_W  read address; stable while imem_req=1.
- imem_ack  input  1  read complete; imem_rdata valid this cycle.
- imem_rdata  input  DATA_W  instruction word.
- redirect_valid  input  1  branch/jump taken, one-cycle pulse.
- redirect_pc  input  DATA_W  target address.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode accepts head.
- inst_data  output  DATA_W  head instruction.
- inst_pc  output  DATA_W  head instruction address.

Behaviour:
- Reset (rst=0, async): state=IDLE, imem_req=0, imem_addr=0, pc_ld=0, pc_next=0, queue empty, inst_valid=0.
- pc_ld and pc_next are registered. pc_in reflects a load two cycles after the cause.
- States:
  - IDLE: if count<DEPTH and no redirect: imem_req←1, imem_addr←pc_in, go REQ.
  - REQ: hold req/addr. On imem_ack: push {imem_addr, imem_rdata}, imem_req←0, pc_next←imem_addr+4 (mod 2^DATA_W, wraps silently), pc_ld←1, go SETTLE.
  - SETTLE: one cycle, the cycle pc_ld is high. Then IDLE.
  - DISCARD: hold req until imem_ack; drop rdata, no push, no pc_ld. Then IDLE.
- Redirect (any state, highest priority):
  - Actions: flush queue (count←0), pc_next←redirect_pc, pc_ld←1.
  - IDLE or SETTLE → SETTLE.
  - REQ with imem_ack in the same cycle → data dropped, → SETTLE.
  - REQ without ack → DISCARD.
  - DISCARD with ack in the same cycle → SETTLE.
  - DISCARD without ack → stay DISCARD (a new pc_ld pulse is issued).
- Queue:
  - FIFO with wrapping read/write pointers and a count of width clog2(DEPTH+1).
  - Pop when inst_valid && inst_ready.
  - inst_valid = count≠0 && !redirect_valid (combinational mask). No pop in a redirect cycle.
  - Push and pop may occur in the same cycle; count is unchanged.
  - Full (count==DEPTH): no new request issued. At most one request is ever outstanding, and issue requires count<DEPTH, so a push never overflows.
  - inst_data/inst_pc = head entry. Their value is don't-care when invalid.
- Throughput: with a 1-cycle ack, one instruction per 3 cycles (IDLE, REQ, SETTLE).
- Reset mid-request: imem_req drops immediately. Memory must tolerate an abandoned request.

Decomposition:
- Shared package: state encoding constants (IDLE, REQ, SETTLE, DISCARD) and the PC increment constant (4).
- One sub-module: fetch_queue, a parameterised synchronous FIFO with push/pop/flush/count/full/empty.

Test Plan:
- Reset: hold rst=0 with PC at 0 → imem_req=0, pc_ld=0, inst_valid=0. Release → imem_req=1, imem_addr=0 the next cycle.
- Straight-line fetch, ack 1 cycle after each req, inst_ready=1 → imem_addr sequence 0,4,8. pc_next 4,8,12, each with a single-cycle pc_ld. inst_pc matches, inst_data = returned words.
- Backpressure, inst_ready=0 → 4 entries fetched (0..12), then imem_req stays 0. Release ready for 1 cycle → one pop, one new fetch at 16.
- Redirect in IDLE with 2 queued, redirect_pc=0x100 → inst_valid=0 that cycle, queue empty, pc_ld=1/pc_next=0x100 the next cycle, next imem_addr=0x100.
- Redirect while REQ pending at 0x20, ack 3 cycles later with 0xDEADBEEF → word not queued, no second pc_ld, next request at redirect_pc.
- Async reset mid-REQ → imem_req drops before the next clock edge, queue empties, and the FSM restarts from the pc_in value supplied after reset.
